// File: rtl/trace_axis_if.sv
// AXI-Stream trace packet channel between the trace FIFO/DMA path and the decoder.
// The beat transfers on a rising clock edge where tvalid and tready are both high.
interface trace_axis_if #(
    parameter int DATA_WIDTH = 116
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/trace_stream_decoder.sv
// Decodes trace monitor packets into records, rebuilds absolute timestamps and
// keeps running event totals; stops after a WFI-terminated frame.
module trace_stream_decoder #(
    parameter int NO_OF_PERFORMANCE_EVENTS            = 4,
    parameter int PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 8,
    parameter int XLEN                                = 32,
    parameter int CLK_COUNTER_WIDTH                   = 16,
    parameter int RISC_V_INSTRUCTION_WIDTH            = 32,
    parameter logic [RISC_V_INSTRUCTION_WIDTH-1:0] WFI_INSTRUCTION = 32'h1050_0073,
    parameter int AXI_DATA_WIDTH = NO_OF_PERFORMANCE_EVENTS * PERFORMANCE_EVENT_MOD_COUNTER_WIDTH
                                   + NO_OF_PERFORMANCE_EVENTS + XLEN + CLK_COUNTER_WIDTH
                                   + RISC_V_INSTRUCTION_WIDTH,
    parameter int TOTAL_WIDTH     = 64,
    parameter int TIMESTAMP_WIDTH = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    trace_axis_if.slave                         s_axis,
    input  logic                                clear,
    output logic                                rec_valid,
    input  logic                                rec_ready,
    output logic [XLEN-1:0]                     rec_pc,
    output logic [RISC_V_INSTRUCTION_WIDTH-1:0] rec_instr,
    output logic [CLK_COUNTER_WIDTH-1:0]        rec_delta,
    output logic [TIMESTAMP_WIDTH-1:0]          rec_timestamp,
    output logic                                rec_last,
    input  logic [5:0]                          total_sel,
    output logic [TOTAL_WIDTH-1:0]              total_value,
    output logic [31:0]                         packet_count,
    output logic [31:0]                         frame_count,
    output logic                                stopped,
    output logic                                err_zero_delta,
    output logic [1:0]                          state_dbg
);
    localparam int N         = NO_OF_PERFORMANCE_EVENTS;
    localparam int W         = PERFORMANCE_EVENT_MOD_COUNTER_WIDTH;
    localparam int OVF_LSB   = N * W;
    localparam int PC_LSB    = OVF_LSB + N;
    localparam int DELTA_LSB = PC_LSB + XLEN;
    localparam int INSTR_LSB = DELTA_LSB + CLK_COUNTER_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    state_t state, state_n;

    logic                                out_en;
    logic                                tready_c;
    logic                                accept;
    logic                                held_wfi;
    logic [N-1:0]                        f_ovf;
    logic [XLEN-1:0]                     f_pc;
    logic [CLK_COUNTER_WIDTH-1:0]        f_delta;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] f_instr;
    logic [TOTAL_WIDTH-1:0]              addend   [N];
    logic [TOTAL_WIDTH-1:0]              totals   [N];
    logic [TIMESTAMP_WIDTH-1:0]          timestamp;
    logic [TIMESTAMP_WIDTH-1:0]          ts_next;
    logic [TOTAL_WIDTH-1:0]              sel_value;

    // Overflow bit i stands for one wrap of the W-bit counter, i.e. 2^W events.
    always_comb begin
        f_ovf   = s_axis.tdata[OVF_LSB +: N];
        f_pc    = s_axis.tdata[PC_LSB +: XLEN];
        f_delta = s_axis.tdata[DELTA_LSB +: CLK_COUNTER_WIDTH];
        f_instr = s_axis.tdata[INSTR_LSB +: RISC_V_INSTRUCTION_WIDTH];
        for (int i = 0; i < N; i++) begin
            addend[i] = TOTAL_WIDTH'(s_axis.tdata[i*W +: W])
                      + (f_ovf[i] ? (TOTAL_WIDTH'(1) << W) : '0);
        end
    end

    assign ts_next  = timestamp + TIMESTAMP_WIDTH'(f_delta);
    assign held_wfi = rec_last & (rec_instr == WFI_INSTRUCTION);

    // out_en keeps tready low until the first clock after reset release.
    always_comb begin
        tready_c = 1'b0;
        case (state)
            ST_IDLE: tready_c = ~clear;
            ST_HOLD: tready_c = rec_ready & ~clear & ~held_wfi;
            default: tready_c = 1'b0;
        endcase
    end

    assign s_axis.tready = out_en & tready_c;
    assign accept        = s_axis.tvalid & s_axis.tready;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_HOLD;
            ST_HOLD: begin
                if (rec_ready) begin
                    if (accept)        state_n = ST_HOLD;
                    else if (held_wfi) state_n = ST_STOPPED;
                    else               state_n = ST_IDLE;
                end
            end
            ST_STOPPED: if (clear) state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    assign rec_valid = (state == ST_HOLD);
    assign stopped   = (state == ST_STOPPED);
    assign state_dbg = state;

    always_comb begin
        sel_value = '0;
        for (int i = 0; i < N; i++) begin
            if (total_sel == 6'(i)) sel_value = totals[i];
        end
    end

    // clear never coincides with accept because clear forces tready low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en         <= 1'b0;
            timestamp      <= '0;
            packet_count   <= '0;
            frame_count    <= '0;
            err_zero_delta <= 1'b0;
            rec_pc         <= '0;
            rec_instr      <= '0;
            rec_delta      <= '0;
            rec_timestamp  <= '0;
            rec_last       <= 1'b0;
            total_value    <= '0;
            for (int i = 0; i < N; i++) totals[i] <= '0;
        end else begin
            out_en      <= 1'b1;
            total_value <= sel_value;
            if (clear) begin
                timestamp      <= '0;
                packet_count   <= '0;
                frame_count    <= '0;
                err_zero_delta <= 1'b0;
                for (int i = 0; i < N; i++) totals[i] <= '0;
            end else if (accept) begin
                for (int i = 0; i < N; i++) totals[i] <= totals[i] + addend[i];
                timestamp     <= ts_next;
                packet_count  <= packet_count + 32'd1;
                frame_count   <= frame_count + 32'(s_axis.tlast);
                if (f_delta == '0 && packet_count != 32'd0) err_zero_delta <= 1'b1;
                rec_pc        <= f_pc;
                rec_instr     <= f_instr;
                rec_delta     <= f_delta;
                rec_timestamp <= ts_next;
                rec_last      <= s_axis.tlast;
            end
        end
    end
endmodule

// File: tb/tb_trace_stream_decoder.sv
// Directed bench for trace_stream_decoder: decode, timestamps, totals, backpressure,
// WFI stop, zero-delta error and asynchronous reset.
module tb_trace_stream_decoder;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int AXW = 116;
  localparam logic [31:0] WFI = 32'h1050_0073;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic [31:0] rec_pc;
  logic [31:0] rec_instr;
  logic [15:0] rec_delta;
  logic [63:0] rec_timestamp;
  logic        rec_last;
  logic [5:0]  total_sel = '0;
  logic [63:0] total_value;
  logic [31:0] packet_count;
  logic [31:0] frame_count;
  logic        stopped;
  logic        err_zero_delta;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_ts = '0;

  trace_axis_if #(.DATA_WIDTH(AXW)) s_axis_if ();

  trace_stream_decoder dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_axis_if), .clear(clear),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_pc(rec_pc),
    .rec_instr(rec_instr), .rec_delta(rec_delta), .rec_timestamp(rec_timestamp),
    .rec_last(rec_last), .total_sel(total_sel), .total_value(total_value),
    .packet_count(packet_count), .frame_count(frame_count), .stopped(stopped),
    .err_zero_delta(err_zero_delta), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AXW-1:0] pack(input logic [31:0] cnts, input logic [3:0] ovf,
                                          input logic [31:0] pc, input logic [15:0] delta,
                                          input logic [31:0] instr);
    return {instr, delta, pc, ovf, cnts};
  endfunction

  // driver: called at a negedge, returns at the negedge after acceptance
  task automatic send_beat(input logic [31:0] cnts, input logic [3:0] ovf, input logic [31:0] pc,
                           input logic [15:0] delta, input logic [31:0] instr, input logic last);
    int  n = 0;
    bit  ok = 0;
    s_axis_if.tvalid = 1'b1;
    s_axis_if.tdata  = pack(cnts, ovf, pc, delta, instr);
    s_axis_if.tlast  = last;
    while (!ok && n < 20) begin
      #1;
      if (s_axis_if.tready) begin
        @(posedge clk);
        ok = 1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    s_axis_if.tvalid = 1'b0;
    if (ok) begin
      model_ts = model_ts + 64'(delta);
      exp_q.push_back(model_ts);
    end
    check("accept_timeout", 64'(ok), 64'd1);
  endtask

  // scoreboard: the newly accepted record must be visible now
  task automatic check_rec(input logic [31:0] pc, input logic [15:0] delta);
    logic [63:0] exp_ts;
    check("rec_valid", 64'(rec_valid), 64'd1);
    check("rec_pc", 64'(rec_pc), 64'(pc));
    check("rec_delta", 64'(rec_delta), 64'(delta));
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL exp_q_empty: got empty expected entry");
    end else begin
      exp_ts = exp_q.pop_front();
      check("rec_timestamp", rec_timestamp, exp_ts);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_ts = '0;
  endtask

  initial begin
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tdata  = '0;
    s_axis_if.tlast  = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_tready", 64'(s_axis_if.tready), 64'd0);
    check("rst_rec_valid", 64'(rec_valid), 64'd0);
    check("rst_stopped", 64'(stopped), 64'd0);
    check("rst_packet_count", 64'(packet_count), 64'd0);
    check("rst_total_value", total_value, 64'd0);
    check("rst_timestamp", rec_timestamp, 64'd0);
    check("rst_err", 64'(err_zero_delta), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    rst_n = 1'b1;
    #1 check("tready_after_release", 64'(s_axis_if.tready), 64'd0);
    @(negedge clk);
    check("tready_first_clock", 64'(s_axis_if.tready), 64'd1);

    // basic decode and timestamp accumulation
    rec_ready = 1'b1;
    send_beat(32'h0, 4'h0, 32'h100, 16'd10, NOP, 1'b0);
    check_rec(32'h100, 16'd10);
    send_beat(32'h0, 4'h0, 32'h104, 16'd3, NOP, 1'b0);
    check_rec(32'h104, 16'd3);
    check("packet_count_2", 64'(packet_count), 64'd2);
    @(negedge clk);
    check("idle_after_consume", 64'(rec_valid), 64'd0);

    // totals with overflow expansion: 0x105+2, 7+1, 0, 0x1ff
    pulse_clear();
    check("clear_packet_count", 64'(packet_count), 64'd0);
    send_beat({8'hff, 8'h00, 8'h05, 8'h07}, 4'b1010, 32'h200, 16'd1, NOP, 1'b0);
    check_rec(32'h200, 16'd1);
    send_beat({8'h00, 8'h00, 8'h02, 8'h01}, 4'b0000, 32'h204, 16'd1, NOP, 1'b0);
    check_rec(32'h204, 16'd1);
    total_sel = 6'd1; @(negedge clk); check("total1", total_value, 64'd263);
    total_sel = 6'd0; @(negedge clk); check("total0", total_value, 64'd8);
    total_sel = 6'd2; @(negedge clk); check("total2", total_value, 64'd0);
    total_sel = 6'd3; @(negedge clk); check("total3", total_value, 64'd511);
    total_sel = 6'd4; @(negedge clk); check("total_sel_n", total_value, 64'd0);
    total_sel = 6'd63; @(negedge clk); check("total_sel_63", total_value, 64'd0);
    total_sel = 6'd0;

    // backpressure: one beat held, next waits for rec_ready
    rec_ready = 1'b0;
    s_axis_if.tvalid = 1'b1;
    s_axis_if.tdata  = pack(32'h0, 4'h0, 32'h300, 16'd5, NOP);
    s_axis_if.tlast  = 1'b0;
    #1 check("bp_first_tready", 64'(s_axis_if.tready), 64'd1);
    @(posedge clk);
    model_ts = model_ts + 64'd5;
    exp_q.push_back(model_ts);
    @(negedge clk);
    s_axis_if.tdata = pack(32'h0, 4'h0, 32'h304, 16'd6, NOP);
    check_rec(32'h300, 16'd5);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_tready_low", 64'(s_axis_if.tready), 64'd0);
      check("bp_rec_stable", {rec_pc, rec_timestamp[31:0]}, {32'h300, 32'd7});
      @(negedge clk);
    end
    rec_ready = 1'b1;
    #1 check("bp_release_tready", 64'(s_axis_if.tready), 64'd1);
    @(posedge clk);
    model_ts = model_ts + 64'd6;
    exp_q.push_back(model_ts);
    @(negedge clk);
    s_axis_if.tvalid = 1'b0;
    check_rec(32'h304, 16'd6);
    check("bp_packet_count", 64'(packet_count), 64'd4);
    @(negedge clk);

    // WFI-terminated frame stops the decoder
    pulse_clear();
    send_beat(32'h0, 4'h0, 32'h400, 16'd2, WFI, 1'b1);
    check_rec(32'h400, 16'd2);
    s_axis_if.tvalid = 1'b1;
    s_axis_if.tdata  = pack(32'h0, 4'h0, 32'h404, 16'd7, NOP);
    s_axis_if.tlast  = 1'b0;
    #1 check("wfi_hold_tready", 64'(s_axis_if.tready), 64'd0);
    @(negedge clk);
    check("stopped", 64'(stopped), 64'd1);
    check("stopped_tready", 64'(s_axis_if.tready), 64'd0);
    check("frame_count", 64'(frame_count), 64'd1);
    check("wfi_packet_count", 64'(packet_count), 64'd1);
    s_axis_if.tvalid = 1'b0;
    pulse_clear();
    check("clear_leaves_stopped", 64'(stopped), 64'd0);
    check("clear_frame_count", 64'(frame_count), 64'd0);
    check("clear_state", 64'(state_dbg), 64'd0);

    // zero delta on a non-first packet is sticky until clear
    send_beat(32'h0, 4'h0, 32'h500, 16'd4, NOP, 1'b0);
    check_rec(32'h500, 16'd4);
    check("err_after_first", 64'(err_zero_delta), 64'd0);
    send_beat(32'h0, 4'h0, 32'h504, 16'd0, NOP, 1'b0);
    check_rec(32'h504, 16'd0);
    check("err_zero_delta", 64'(err_zero_delta), 64'd1);
    send_beat(32'h0, 4'h0, 32'h508, 16'd2, NOP, 1'b0);
    check_rec(32'h508, 16'd2);
    check("err_sticky", 64'(err_zero_delta), 64'd1);
    @(negedge clk);
    pulse_clear();
    check("err_cleared", 64'(err_zero_delta), 64'd0);

    // reset while a record is held
    rec_ready = 1'b0;
    send_beat(32'h0000_0009, 4'h0, 32'h600, 16'd0, NOP, 1'b0);
    check_rec(32'h600, 16'd0);
    check("err_first_zero_after_clear", 64'(err_zero_delta), 64'd0);
    @(negedge clk);
    check("held_total0", total_value, 64'd9);
    #3 rst_n = 1'b0;
    #1;
    check("async_rec_valid", 64'(rec_valid), 64'd0);
    check("async_total", total_value, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_ts = '0;
    @(negedge clk);
    check("post_reset_total", total_value, 64'd0);
    rec_ready = 1'b1;
    send_beat(32'h0, 4'h0, 32'h700, 16'd0, NOP, 1'b0);
    check_rec(32'h700, 16'd0);
    check("err_first_zero_after_reset", 64'(err_zero_delta), 64'd0);
    check("post_reset_packet_count", 64'(packet_count), 64'd1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
